// File: rtl/se_fc_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : se_fc_accumulator
// Description : Fully-connected neuron accumulator. Sums packed lane products
//               over a number of beats, adds bias, applies ReLU/hard-sigmoid.
// Revision    : 1.0 - initial release
// ============================================================================
module se_fc_accumulator #(
    parameter int bitsize       = 14,
    parameter int FRAC_BITS     = 7,
    parameter int NUM_INSTANCES = 32,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [CNT_WIDTH-1:0]                                  num_beats,
    input  logic signed [bitsize-1:0]                             bias,
    input  logic                                                  act_sel,
    input  logic signed [NUM_INSTANCES*(2*bitsize-FRAC_BITS)-1:0] Mul_result,
    input  logic                                                  valid,
    output logic                                                  busy,
    output logic signed [bitsize-1:0]                             result,
    output logic                                                  out_valid
);

    localparam int LANE_W = 2*bitsize - FRAC_BITS;
    localparam int ACC_W  = LANE_W + $clog2(NUM_INSTANCES) + CNT_WIDTH;
    // Two guard bits so acc + bias + sigmoid offset can never wrap.
    localparam int ACT_W  = ACC_W + 2;

    localparam logic signed [ACT_W-1:0] HS_OFFSET = ACT_W'(3 << FRAC_BITS);
    localparam logic signed [ACT_W-1:0] HS_MAX    = ACT_W'(6 << FRAC_BITS);
    localparam logic signed [ACT_W-1:0] HS_ONE    = ACT_W'(1 << FRAC_BITS);
    localparam logic signed [ACT_W-1:0] HS_MUL    = ACT_W'(43);
    localparam logic signed [ACT_W-1:0] SAT_MAX   = ACT_W'((1 << (bitsize-1)) - 1);
    localparam logic signed [ACT_W-1:0] SAT_MIN   = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       w_beat_take;
    logic signed [ACC_W-1:0]    r_acc;
    logic [CNT_WIDTH-1:0]       r_beat_cnt;
    logic [CNT_WIDTH-1:0]       r_num_beats;
    logic signed [bitsize-1:0]  r_bias;
    logic                       r_act_sel;

    logic signed [ACC_W-1:0]    w_beat_sum;
    logic signed [ACT_W-1:0]    w_sum;
    logic signed [ACT_W-1:0]    w_relu;
    logic signed [ACT_W-1:0]    w_hs;
    logic signed [ACT_W-1:0]    w_hs_clamp;
    logic signed [ACT_W-1:0]    w_hs_prod;
    logic signed [ACT_W-1:0]    w_hs_scaled;
    logic signed [ACT_W-1:0]    w_hs_y;
    logic signed [ACT_W-1:0]    w_y;
    logic signed [bitsize-1:0]  w_sat;

    assign busy = (r_state != IDLE);

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < NUM_INSTANCES; i++) begin
            w_beat_sum = w_beat_sum + {{(ACC_W-LANE_W){Mul_result[i*LANE_W+LANE_W-1]}},
                                       Mul_result[i*LANE_W +: LANE_W]};
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_beat_take  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (num_beats == '0) ? FINISH : ACCUM;
                end
            end
            ACCUM: begin
                if (valid) begin
                    w_beat_take = 1'b1;
                    if (r_beat_cnt == r_num_beats - CNT_WIDTH'(1)) begin
                        w_next_state = FINISH;
                    end
                end
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Activation datapath, only consumed in FINISH.
    always_comb begin
        w_sum       = {{2{r_acc[ACC_W-1]}}, r_acc}
                    + {{(ACT_W-bitsize){r_bias[bitsize-1]}}, r_bias};
        w_relu      = (w_sum < 0) ? '0 : w_sum;
        w_hs        = w_sum + HS_OFFSET;
        w_hs_clamp  = (w_hs < 0) ? '0 : ((w_hs > HS_MAX) ? HS_MAX : w_hs);
        w_hs_prod   = w_hs_clamp * HS_MUL;
        w_hs_scaled = w_hs_prod >>> 8;
        w_hs_y      = (w_hs_scaled > HS_ONE) ? HS_ONE : w_hs_scaled;
        w_y         = r_act_sel ? w_hs_y : w_relu;
        if (w_y > SAT_MAX) begin
            w_sat = SAT_MAX[bitsize-1:0];
        end else if (w_y < SAT_MIN) begin
            w_sat = SAT_MIN[bitsize-1:0];
        end else begin
            w_sat = w_y[bitsize-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_num_beats <= '0;
            r_bias      <= '0;
            r_act_sel   <= 1'b0;
            result      <= '0;
            out_valid   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            out_valid <= 1'b0;
            if (r_state == IDLE && start) begin
                r_acc       <= '0;
                r_beat_cnt  <= '0;
                r_num_beats <= num_beats;
                r_bias      <= bias;
                r_act_sel   <= act_sel;
            end
            if (w_beat_take) begin
                r_acc      <= r_acc + w_beat_sum;
                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            end
            if (r_state == FINISH) begin
                result    <= w_sat;
                out_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_se_fc_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_se_fc_accumulator
// Description : Self-checking bench: vector table, corner sequences, random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_se_fc_accumulator;

    localparam int BITSIZE = 14;
    localparam int FRAC    = 7;
    localparam int NI      = 32;
    localparam int CNTW    = 8;
    localparam int LANE_W  = 2*BITSIZE - FRAC;
    localparam int MW      = NI*LANE_W;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic [CNTW-1:0]            num_beats;
    logic signed [BITSIZE-1:0]  bias;
    logic                       act_sel;
    logic signed [MW-1:0]       mul_result;
    logic                       valid;
    logic                       busy;
    logic signed [BITSIZE-1:0]  result;
    logic                       out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [MW-1:0] beats[$];

    typedef struct {
        bit act;
        int b;
        int nb;
        int lane0;
        int others;
        int exp;
    } vec_t;
    vec_t vecs[10];

    se_fc_accumulator #(
        .bitsize(BITSIZE), .FRAC_BITS(FRAC), .NUM_INSTANCES(NI), .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_beats(num_beats), .bias(bias),
        .act_sel(act_sel), .Mul_result(mul_result), .valid(valid), .busy(busy),
        .result(result), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] make_beat(input int l0, input int oth);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < NI; i++) begin
            v[i*LANE_W +: LANE_W] = (i == 0) ? l0[LANE_W-1:0] : oth[LANE_W-1:0];
        end
        return v;
    endfunction

    // Reference: plain arithmetic on the beats queue.
    function automatic longint model(input bit act, input longint b, input int nb);
        longint s, c, y;
        logic signed [LANE_W-1:0] lane;
        s = b;
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < NI; i++) begin
                lane = beats[k][i*LANE_W +: LANE_W];
                s += lane;
            end
        end
        if (!act) begin
            y = (s < 0) ? 0 : s;
        end else begin
            c = s + 3*(1 << FRAC);
            if (c < 0) c = 0;
            if (c > 6*(1 << FRAC)) c = 6*(1 << FRAC);
            y = (c*43) / 256;
            if (y > (1 << FRAC)) y = (1 << FRAC);
        end
        if (y > (1 << (BITSIZE-1)) - 1) y = (1 << (BITSIZE-1)) - 1;
        if (y < -(1 << (BITSIZE-1))) y = -(1 << (BITSIZE-1));
        return y;
    endfunction

    // Called #1 after a rising edge with the DUT idle (or in its out_valid cycle).
    // Returns #1 after the edge that raises out_valid.
    task automatic run_neuron(input bit act, input int b, input int nb, input int max_gap,
                              input bit noisy, input string name, input longint exp);
        int gap;
        if (noisy) begin
            valid = 1'b1;
            mul_result = make_beat(1000, 1000);
            @(posedge clk); #1;
            valid = 1'b0;
        end
        start = 1'b1; num_beats = CNTW'(nb); bias = BITSIZE'(b); act_sel = act;
        @(posedge clk); #1;
        start = 1'b0; num_beats = CNTW'(nb + 3); bias = ~bias; act_sel = ~act;
        for (int k = 0; k < nb; k++) begin
            gap = noisy ? (k % 3) : int'($urandom_range(0, max_gap));
            repeat (gap) begin
                valid = 1'b0;
                start = noisy;
                @(posedge clk); #1;
                start = 1'b0;
            end
            valid = 1'b1;
            mul_result = beats[k];
            @(posedge clk); #1;
            valid = 1'b0;
        end
        check({name, "/busy_finish"}, busy, 1);
        check({name, "/ov_early"}, out_valid, 0);
        if (noisy) begin
            valid = 1'b1; start = 1'b1; mul_result = make_beat(777, 5);
        end
        @(posedge clk); #1;
        valid = 1'b0; start = 1'b0;
        check({name, "/out_valid"}, out_valid, 1);
        check({name, "/result"}, result, exp);
        check({name, "/busy_idle"}, busy, 0);
    endtask

    task automatic pulse_end(input string name, input longint exp);
        @(posedge clk); #1;
        check({name, "/ov_drop"}, out_valid, 0);
        check({name, "/hold"}, result, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; num_beats = '0; bias = '0;
        act_sel = 1'b0; mul_result = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy", busy, 0);
        check("reset/result", result, 0);
        check("reset/out_valid", out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs[0] = '{0,    0, 2,  128, 128, 8191};
        vecs[1] = '{0,   64, 1, -256,   0,    0};
        vecs[2] = '{1,    0, 0,    0,   0,   64};
        vecs[3] = '{1, -512, 0,    0,   0,    0};
        vecs[4] = '{1,  512, 0,    0,   0,  128};
        vecs[5] = '{0,  -44, 1,  300,   0,  256};
        vecs[6] = '{1,    0, 1,  100,   0,   81};
        vecs[7] = '{0, -100, 0,    0,   0,    0};
        vecs[8] = '{0, 4000, 0,    0,   0, 4000};
        vecs[9] = '{0,    5, 3,    1,   1,  101};
        for (int i = 0; i < 10; i++) begin
            beats = {};
            for (int k = 0; k < vecs[i].nb; k++) beats.push_back(make_beat(vecs[i].lane0, vecs[i].others));
            run_neuron(vecs[i].act, vecs[i].b, vecs[i].nb, 1, 1'b0, $sformatf("vec%0d", i), vecs[i].exp);
            pulse_end($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in the middle of accumulation, then a fresh neuron.
        beats = {make_beat(11, 3)};
        start = 1'b1; num_beats = 4; bias = '0; act_sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            valid = 1'b1; mul_result = beats[0];
            @(posedge clk); #1;
        end
        valid = 1'b0;
        check("midrst/busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst/busy", busy, 0);
        check("midrst/result", result, 0);
        check("midrst/out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            valid = 1'b1; mul_result = make_beat(400, 9);
            @(posedge clk); #1;
            check("midrst/no_accept", busy, 0);
        end
        valid = 1'b0;
        beats = {make_beat(5, 2)};
        run_neuron(1'b0, 3, 1, 0, 1'b0, "midrst_fresh", 70);
        pulse_end("midrst_fresh", 70);

        // Stalls, beats in IDLE/FINISH and start while busy are ignored.
        beats = {make_beat(100, 1), make_beat(-50, 2), make_beat(7, 0)};
        run_neuron(1'b0, 20, 3, 2, 1'b1, "stall", 170);
        pulse_end("stall", 170);

        // Back-to-back: second start in the out_valid cycle.
        beats = {make_beat(64, 0)};
        run_neuron(1'b0, 0, 1, 0, 1'b0, "b2b_a", 64);
        beats = {make_beat(-20, 0)};
        run_neuron(1'b1, 0, 1, 0, 1'b0, "b2b_b", 61);
        pulse_end("b2b_b", 61);

        for (int t = 0; t < 30; t++) begin
            bit act, b2b;
            int b, nb, mag;
            longint exp;
            act = 1'($urandom_range(0, 1));
            b   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16383)) - 8192
                                              : int'($urandom_range(0, 1200)) - 600;
            nb  = int'($urandom_range(0, 6));
            mag = 1 << $urandom_range(2, 20);
            beats = {};
            for (int k = 0; k < nb; k++) begin
                logic [MW-1:0] v;
                int lv;
                for (int i = 0; i < NI; i++) begin
                    lv = int'($urandom_range(0, 2*mag - 1)) - mag;
                    v[i*LANE_W +: LANE_W] = lv[LANE_W-1:0];
                end
                beats.push_back(v);
            end
            exp = model(act, b, nb);
            b2b = (t != 29) && ($urandom_range(0, 1) == 1);
            run_neuron(act, b, nb, 2, 1'b0, $sformatf("rand%0d", t), exp);
            if (!b2b) pulse_end($sformatf("rand%0d", t), exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/se_fc_accumulator.md
SE_FC_ACCUMULATOR -- requirements
Module: se_fc_accumulator

Interface
REQ-001 The module SHALL have parameter bitsize, default 14, giving the width of the signed activation, bias and output words.
REQ-002 The module SHALL have parameter FRAC_BITS, default 7, giving the fractional bits of every Q-format word (lane products, bias, output).
REQ-003 The module SHALL have parameter NUM_INSTANCES, default 32, giving the number of product lanes per beat.
REQ-004 The module SHALL have parameter CNT_WIDTH, default 8, giving the width of the beat count.
REQ-005 The module SHALL derive localparam LANE_W = 2*bitsize-FRAC_BITS (21) and localparam ACC_W = LANE_W+clog2(NUM_INSTANCES)+CNT_WIDTH (34).
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: requests a new neuron computation; sampled only in IDLE.
REQ-009 Port num_beats, input, CNT_WIDTH: number of product beats making up the neuron; latched on accepted start.
REQ-010 Port bias, input, bitsize signed: neuron bias in Q(FRAC_BITS); latched on accepted start.
REQ-011 Port act_sel, input, 1: 0 = ReLU, 1 = hard-sigmoid; latched on accepted start.
REQ-012 Port Mul_result, input, NUM_INSTANCES*LANE_W signed: packed lane products from the upstream multiplier array, lane i at bits [i*LANE_W +: LANE_W].
REQ-013 Port valid, input, 1: high when Mul_result holds one beat.
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Port result, output, bitsize signed: activated neuron output in Q(FRAC_BITS).
REQ-016 Port out_valid, output, 1: one-cycle pulse marking result as new.

Function
REQ-017 The FSM SHALL have states IDLE, ACCUM and FINISH.
REQ-018 In IDLE with start=1, the block SHALL clear acc and beat_cnt, latch num_beats, bias and act_sel, and go to ACCUM; if num_beats=0 it SHALL go directly to FINISH.
REQ-019 In ACCUM, each cycle with valid=1 SHALL add the sign-extended sum of all NUM_INSTANCES lanes to acc and increment beat_cnt; valid=0 SHALL hold acc, beat_cnt and the state.
REQ-020 In ACCUM, the beat accepted when beat_cnt = latched num_beats-1 SHALL be accumulated and the FSM SHALL move to FINISH on the same edge.
REQ-021 In FINISH, the block SHALL form s = acc + sign-extended bias and apply the activation.
REQ-022 ReLU SHALL give y = max(s,0); hard-sigmoid SHALL give c = clamp(s+(3<<FRAC_BITS), 0, 6<<FRAC_BITS), then y = min((c*43)>>8, 1<<FRAC_BITS).
REQ-023 In FINISH, the block SHALL saturate y to [-(2^(bitsize-1)), 2^(bitsize-1)-1] and register it on result.
REQ-024 In FINISH, the block SHALL drive out_valid=1 for exactly the following cycle and return to IDLE.
REQ-025 Latency SHALL be result/out_valid visible one cycle after the edge that accepts the final beat.
REQ-026 result SHALL hold its value until the next out_valid.
REQ-027 valid in IDLE or FINISH, and start outside IDLE, SHALL be ignored; dropped beats SHALL NOT affect acc.
REQ-028 acc SHALL NOT overflow for any input within range, since ACC_W covers NUM_INSTANCES*(2^CNT_WIDTH-1) full-scale products.
REQ-029 A start in the same cycle as the out_valid pulse SHALL be accepted, because the FSM is already in IDLE.

Reset
REQ-030 While rst=1, the block SHALL force the state to IDLE, acc=0, beat_cnt=0, result=0, out_valid=0 and busy=0, asynchronously and including mid-computation.
REQ-031 After rst deasserts, the block SHALL accept no beat until a new start.

Verification
REQ-032 Reset mid-ACCUM: raise rst after 2 of 4 beats -> busy=0, result=0 and out_valid=0 immediately; then run a fresh 1-beat neuron -> result reflects that neuron only.
REQ-033 ReLU, num_beats=2: every lane = 1.0 (128) on both beats, bias=0 -> s=8192 saturates, result=8191, one out_valid pulse one cycle after beat 2.
REQ-034 ReLU negative, num_beats=1: lane0=-256, others 0, bias=64 -> result=0.
REQ-035 Hard-sigmoid, num_beats=0, bias=0 -> c=384, result=(384*43)>>8=64 (0.5); bias=-512 -> result=0; bias=512 -> result=128.
REQ-036 Stalls and ignored inputs, num_beats=3 with valid gaps of 0-2 cycles, extra valid in IDLE and start while busy -> result equals the sum of exactly 3 beats plus bias, with a single out_valid pulse.
REQ-037 Back-to-back: start asserted in the out_valid cycle -> second neuron accepted and its result is independent of the first.
